data_cache: RTL and testbench

// Direct-mapped, write-back, write-allocate data cache between the MA (memory-access) pipeline stage and DDR.

---
 rtl/data_cache.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_data_cache.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-back, write-allocate data cache sitting between the
//   memory-access (MA) pipeline stage and DDR. MA issues 32-bit word reads and
//   writes; DDR is accessed in whole 128-bit lines (4 words). Only one MA
//   request is in flight at a time. A dirty victim line is written back before
//   the new line is refilled.
//
// Ports
//   clk, rstn               single rising-edge clock, async active-low reset
//   MA2cache_rd_addr/_en    MA word read request (en is a one-cycle pulse)
//   cache2MA_rd_fin/_data   read completion pulse, data held until next fin
//   MA2cache_wr_addr/_data/_en   MA word write request (one-cycle pulse)
//   cache2MA_wr_fin         write completion pulse
//   cache2DDR_rd_addr/_en   line refill request (addr[3:0] = 0)
//   DDR2cache_rd_fin/_data  refill line delivery, word w at bits [32w+31:32w]
//   cache2DDR_wr_addr/_data/_en  victim line write-back request
//   DDR2cache_wr_fin        write-back completion pulse
//
// Address split: [1:0] byte (ignored), [3:2] word, [INDEX_W+3:4] index,
// [26:INDEX_W+4] tag.
// -----------------------------------------------------------------------------
module data_cache #(
  parameter int INDEX_W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [26:0]  MA2cache_rd_addr,
  input  logic         MA2cache_rd_en,
  output logic         cache2MA_rd_fin,
  output logic [31:0]  cache2MA_rd_data,
  output logic [26:0]  cache2DDR_rd_addr,
  output logic         cache2DDR_rd_en,
  input  logic         DDR2cache_rd_fin,
  input  logic [127:0] DDR2cache_rd_data,
  input  logic [26:0]  MA2cache_wr_addr,
  input  logic [31:0]  MA2cache_wr_data,
  input  logic         MA2cache_wr_en,
  output logic         cache2MA_wr_fin,
  output logic [26:0]  cache2DDR_wr_addr,
  output logic [127:0] cache2DDR_wr_data,
  output logic         cache2DDR_wr_en,
  input  logic         DDR2cache_wr_fin
);

  localparam int TAG_W = 27 - INDEX_W - 4;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB_REQ    = 3'd2,
    S_WB_WAIT   = 3'd3,
    S_FILL_REQ  = 3'd4,
    S_FILL_WAIT = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  // Extract the selected word from a 128-bit line.
  function automatic logic [31:0] get_word(input logic [127:0] line, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      2'd3:    w = line[127:96];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Return the input line with the selected word replaced by the given word.
  function automatic logic [127:0] put_word(input logic [127:0] line, input logic [1:0] sel,
                                            input logic [31:0] w);
    logic [127:0] t;
    t = line;
    case (sel)
      2'd0:    t[31:0]   = w;
      2'd1:    t[63:32]  = w;
      2'd2:    t[95:64]  = w;
      2'd3:    t[127:96] = w;
      default: t = line;
    endcase
    return t;
  endfunction

  // FSM state
  state_t r_state;
  state_t w_state_nxt;

  // Latched MA request
  logic               r_req_wr;
  logic [1:0]         r_req_word;
  logic [INDEX_W-1:0] r_req_idx;
  logic [TAG_W-1:0]   r_req_tag;
  logic [31:0]        r_req_wdata;

  // Line storage: valid/dirty need reset, tag/data arrays do not
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag_mem  [LINES];
  logic [127:0]       r_data_mem [LINES];

  // Registered outputs
  logic               r_rd_fin;
  logic [31:0]        r_rd_data;
  logic [26:0]        r_ddr_rd_addr;
  logic               r_ddr_rd_en;
  logic               r_wr_fin;
  logic [26:0]        r_ddr_wr_addr;
  logic [127:0]       r_ddr_wr_data;
  logic               r_ddr_wr_en;

  // Next values for registered outputs
  logic               w_rd_fin_nxt;
  logic [31:0]        w_rd_data_nxt;
  logic [26:0]        w_ddr_rd_addr_nxt;
  logic               w_ddr_rd_en_nxt;
  logic               w_wr_fin_nxt;
  logic [26:0]        w_ddr_wr_addr_nxt;
  logic [127:0]       w_ddr_wr_data_nxt;
  logic               w_ddr_wr_en_nxt;

  // Selected line view for the latched request
  logic [127:0]       w_line;
  logic [TAG_W-1:0]   w_line_tag;
  logic               w_line_valid;
  logic               w_line_dirty;
  logic               w_hit;
  logic               w_fill_we;
  logic               w_resp_we;
  logic               w_unused_byte;

  assign w_line       = r_data_mem[r_req_idx];
  assign w_line_tag   = r_tag_mem[r_req_idx];
  assign w_line_valid = r_valid[r_req_idx];
  assign w_line_dirty = r_dirty[r_req_idx];
  assign w_hit        = w_line_valid && (w_line_tag == r_req_tag);
  assign w_fill_we    = (r_state == S_FILL_WAIT) && DDR2cache_rd_fin;
  assign w_resp_we    = (r_state == S_RESP) && r_req_wr;

  // Byte offset within a word is not used: accesses are word-aligned.
  assign w_unused_byte = ^{MA2cache_rd_addr[1:0], MA2cache_wr_addr[1:0]};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_rd_fin_nxt      = 1'b0;
    w_rd_data_nxt     = r_rd_data;
    w_ddr_rd_addr_nxt = r_ddr_rd_addr;
    w_ddr_rd_en_nxt   = 1'b0;
    w_wr_fin_nxt      = 1'b0;
    w_ddr_wr_addr_nxt = r_ddr_wr_addr;
    w_ddr_wr_data_nxt = r_ddr_wr_data;
    w_ddr_wr_en_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MA2cache_wr_en || MA2cache_rd_en) begin
          w_state_nxt = S_LOOKUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_state_nxt = S_RESP;
        end else if (w_line_valid && w_line_dirty) begin
          w_state_nxt = S_WB_REQ;
        end else begin
          w_state_nxt = S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        w_ddr_wr_en_nxt   = 1'b1;
        w_ddr_wr_addr_nxt = {w_line_tag, r_req_idx, 4'b0000};
        w_ddr_wr_data_nxt = w_line;
        w_state_nxt       = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (DDR2cache_wr_fin) begin
          w_state_nxt = S_FILL_REQ;
        end else begin
          w_state_nxt = S_WB_WAIT;
        end
      end
      S_FILL_REQ: begin
        w_ddr_rd_en_nxt   = 1'b1;
        w_ddr_rd_addr_nxt = {r_req_tag, r_req_idx, 4'b0000};
        w_state_nxt       = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (DDR2cache_rd_fin) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_FILL_WAIT;
        end
      end
      S_RESP: begin
        if (r_req_wr) begin
          w_wr_fin_nxt = 1'b1;
        end else begin
          w_rd_fin_nxt  = 1'b1;
          w_rd_data_nxt = get_word(w_line, r_req_word);
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture in IDLE; a simultaneous read is dropped in favour of the write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req_wr    <= 1'b0;
      r_req_word  <= 2'd0;
      r_req_idx   <= '0;
      r_req_tag   <= '0;
      r_req_wdata <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (MA2cache_wr_en) begin
        r_req_wr    <= 1'b1;
        r_req_word  <= MA2cache_wr_addr[3:2];
        r_req_idx   <= MA2cache_wr_addr[INDEX_W+3:4];
        r_req_tag   <= MA2cache_wr_addr[26:INDEX_W+4];
        r_req_wdata <= MA2cache_wr_data;
      end else if (MA2cache_rd_en) begin
        r_req_wr    <= 1'b0;
        r_req_word  <= MA2cache_rd_addr[3:2];
        r_req_idx   <= MA2cache_rd_addr[INDEX_W+3:4];
        r_req_tag   <= MA2cache_rd_addr[26:INDEX_W+4];
      end
    end
  end

  // Valid/dirty bookkeeping: refill installs a clean line, a write marks it dirty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_we) begin
      r_valid[r_req_idx] <= 1'b1;
      r_dirty[r_req_idx] <= 1'b0;
    end else if (w_resp_we) begin
      r_dirty[r_req_idx] <= 1'b1;
    end
  end

  // Tag/data arrays; contents are qualified by r_valid so they need no reset
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_tag_mem[r_req_idx]  <= r_req_tag;
      r_data_mem[r_req_idx] <= DDR2cache_rd_data;
    end else if (w_resp_we) begin
      r_data_mem[r_req_idx] <= put_word(w_line, r_req_word, r_req_wdata);
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_fin      <= 1'b0;
      r_rd_data     <= 32'd0;
      r_ddr_rd_addr <= 27'd0;
      r_ddr_rd_en   <= 1'b0;
      r_wr_fin      <= 1'b0;
      r_ddr_wr_addr <= 27'd0;
      r_ddr_wr_data <= 128'd0;
      r_ddr_wr_en   <= 1'b0;
    end else begin
      r_rd_fin      <= w_rd_fin_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_ddr_rd_addr <= w_ddr_rd_addr_nxt;
      r_ddr_rd_en   <= w_ddr_rd_en_nxt;
      r_wr_fin      <= w_wr_fin_nxt;
      r_ddr_wr_addr <= w_ddr_wr_addr_nxt;
      r_ddr_wr_data <= w_ddr_wr_data_nxt;
      r_ddr_wr_en   <= w_ddr_wr_en_nxt;
    end
  end

  assign cache2MA_rd_fin   = r_rd_fin;
  assign cache2MA_rd_data  = r_rd_data;
  assign cache2DDR_rd_addr = r_ddr_rd_addr;
  assign cache2DDR_rd_en   = r_ddr_rd_en;
  assign cache2MA_wr_fin   = r_wr_fin;
  assign cache2DDR_wr_addr = r_ddr_wr_addr;
  assign cache2DDR_wr_data = r_ddr_wr_data;
  assign cache2DDR_wr_en   = r_ddr_wr_en;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache. A fixed-latency, zero-initialised DDR
// model answers line requests; a flat word-addressed memory plus a simple
// per-index tag/valid/dirty table predict read data, hits and DDR traffic.
module tb_data_cache;

  localparam int LAT = 4;

  logic         clk;
  logic         rstn;
  logic [26:0]  MA2cache_rd_addr;
  logic         MA2cache_rd_en;
  logic         cache2MA_rd_fin;
  logic [31:0]  cache2MA_rd_data;
  logic [26:0]  cache2DDR_rd_addr;
  logic         cache2DDR_rd_en;
  logic         DDR2cache_rd_fin;
  logic [127:0] DDR2cache_rd_data;
  logic [26:0]  MA2cache_wr_addr;
  logic [31:0]  MA2cache_wr_data;
  logic         MA2cache_wr_en;
  logic         cache2MA_wr_fin;
  logic [26:0]  cache2DDR_wr_addr;
  logic [127:0] cache2DDR_wr_data;
  logic         cache2DDR_wr_en;
  logic         DDR2cache_wr_fin;

  int err_cnt = 0;
  int chk_cnt = 0;

  data_cache #(.INDEX_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .MA2cache_rd_addr(MA2cache_rd_addr), .MA2cache_rd_en(MA2cache_rd_en),
    .cache2MA_rd_fin(cache2MA_rd_fin), .cache2MA_rd_data(cache2MA_rd_data),
    .cache2DDR_rd_addr(cache2DDR_rd_addr), .cache2DDR_rd_en(cache2DDR_rd_en),
    .DDR2cache_rd_fin(DDR2cache_rd_fin), .DDR2cache_rd_data(DDR2cache_rd_data),
    .MA2cache_wr_addr(MA2cache_wr_addr), .MA2cache_wr_data(MA2cache_wr_data),
    .MA2cache_wr_en(MA2cache_wr_en), .cache2MA_wr_fin(cache2MA_wr_fin),
    .cache2DDR_wr_addr(cache2DDR_wr_addr), .cache2DDR_wr_data(cache2DDR_wr_data),
    .cache2DDR_wr_en(cache2DDR_wr_en), .DDR2cache_wr_fin(DDR2cache_wr_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DDR model ----------------
  logic [127:0] ddr_mem [logic [22:0]];
  int           ddr_wr_cnt = 0;
  int           ddr_rd_cnt = 0;
  logic [26:0]  ddr_last_wr_addr = 27'd0;
  logic [127:0] ddr_last_wr_data = 128'd0;
  logic [26:0]  ddr_last_rd_addr = 27'd0;

  function automatic logic [127:0] ddr_line(input logic [22:0] key);
    if (ddr_mem.exists(key)) return ddr_mem[key];
    return 128'd0;
  endfunction

  initial begin
    logic abort;
    logic [26:0] a;
    logic [127:0] d;
    DDR2cache_rd_fin  = 1'b0;
    DDR2cache_wr_fin  = 1'b0;
    DDR2cache_rd_data = 128'd0;
    forever begin
      @(negedge clk);
      if (rstn && cache2DDR_wr_en) begin
        a = cache2DDR_wr_addr; d = cache2DDR_wr_data;
        ddr_wr_cnt++; ddr_last_wr_addr = a; ddr_last_wr_data = d;
        ddr_mem[a[26:4]] = d;
        abort = 1'b0;
        for (int i = 0; i < LAT; i++) begin
          @(negedge clk);
          if (!rstn) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          DDR2cache_wr_fin = 1'b1;
          @(negedge clk);
          DDR2cache_wr_fin = 1'b0;
        end
      end else if (rstn && cache2DDR_rd_en) begin
        a = cache2DDR_rd_addr;
        ddr_rd_cnt++; ddr_last_rd_addr = a;
        abort = 1'b0;
        for (int i = 0; i < LAT; i++) begin
          @(negedge clk);
          if (!rstn) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          DDR2cache_rd_data = ddr_line(a[26:4]);
          DDR2cache_rd_fin  = 1'b1;
          @(negedge clk);
          DDR2cache_rd_fin  = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [24:0]];
  bit          ref_valid [256];
  bit          ref_dirty [256];
  logic [14:0] ref_tag   [256];

  function automatic logic [26:0] mk_addr(input int tag, input int idx, input int w);
    logic [26:0] a;
    a = {tag[14:0], idx[7:0], w[1:0], 2'b00};
    return a;
  endfunction

  function automatic logic [31:0] ref_word(input logic [26:0] a);
    logic [127:0] l;
    if (ref_mem.exists(a[26:2])) return ref_mem[a[26:2]];
    l = ddr_line(a[26:4]);
    return l[{a[3:2], 5'b00000} +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [26:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_word({a[26:4], w[1:0], 2'b00});
    return l;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) begin
      ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = 15'd0;
    end
    ref_mem.delete();
  endtask

  // One MA request with full checking. `addr` is the served address; when
  // both wr and rd are set, rd_en is also raised at `raddr` and must be dropped.
  task automatic do_req(input string nm, input bit wr, input bit rd, input logic [26:0] addr,
                        input logic [31:0] wd, input logic [26:0] raddr, input bit poke);
    logic [7:0]   idx;
    logic [14:0]  tag;
    bit           hit, wb, got, wrong;
    logic [26:0]  vaddr;
    logic [127:0] exp_vline;
    logic [31:0]  exp_rd;
    int           wc0, rc0, edges;
    logic         fin_now;
    idx = addr[11:4]; tag = addr[26:12];
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    wb  = !hit && ref_valid[idx] && ref_dirty[idx];
    vaddr = {ref_tag[idx], idx, 4'b0000};
    exp_vline = ref_line(vaddr);
    exp_rd = ref_word(addr);
    wc0 = ddr_wr_cnt; rc0 = ddr_rd_cnt;
    @(negedge clk);
    if (wr) begin MA2cache_wr_addr = addr; MA2cache_wr_data = wd; MA2cache_wr_en = 1'b1; end
    if (rd) begin MA2cache_rd_addr = wr ? raddr : addr; MA2cache_rd_en = 1'b1; end
    @(posedge clk); #1;
    MA2cache_wr_en = 1'b0; MA2cache_rd_en = 1'b0;
    edges = 1; got = 1'b0; wrong = 1'b0;
    while (!got && edges < 400) begin
      if (poke && edges == 2) begin
        MA2cache_wr_addr = addr ^ 27'h4; MA2cache_wr_data = 32'hBADBAD00; MA2cache_wr_en = 1'b1;
      end else if (poke && edges == 3) begin
        MA2cache_wr_en = 1'b0;
      end
      @(posedge clk); edges++; #1;
      if (wr ? cache2MA_wr_fin : cache2MA_rd_fin) got = 1'b1;
      if (wr ? cache2MA_rd_fin : cache2MA_wr_fin) wrong = 1'b1;
    end
    MA2cache_wr_en = 1'b0;
    chk_cnt++;
    if (got !== 1'b1) begin err_cnt++; $display("FAIL %s timeout: fin=%0b required 1 within 400 cycles", nm, got); end
    chk_cnt++;
    if (wrong !== 1'b0) begin err_cnt++; $display("FAIL %s wrong_fin: other fin pulsed=%0b required 0", nm, wrong); end
    if (hit) begin
      chk_cnt++;
      if (edges !== 3) begin err_cnt++; $display("FAIL %s hit_latency: got %0d edges required 3", nm, edges); end
    end
    chk_cnt++;
    if (ddr_wr_cnt - wc0 !== (wb ? 1 : 0)) begin
      err_cnt++; $display("FAIL %s ddr_wr_count: got %0d required %0d", nm, ddr_wr_cnt - wc0, wb ? 1 : 0);
    end
    chk_cnt++;
    if (ddr_rd_cnt - rc0 !== (hit ? 0 : 1)) begin
      err_cnt++; $display("FAIL %s ddr_rd_count: got %0d required %0d", nm, ddr_rd_cnt - rc0, hit ? 0 : 1);
    end
    if (wb) begin
      chk_cnt++;
      if (ddr_last_wr_addr !== vaddr || ddr_last_wr_data !== exp_vline) begin
        err_cnt++;
        $display("FAIL %s writeback: got %h/%h required %h/%h", nm, ddr_last_wr_addr, ddr_last_wr_data, vaddr, exp_vline);
      end
    end
    if (!hit) begin
      chk_cnt++;
      if (ddr_last_rd_addr !== {addr[26:4], 4'b0000}) begin
        err_cnt++; $display("FAIL %s refill_addr: got %h required %h", nm, ddr_last_rd_addr, {addr[26:4], 4'b0000});
      end
    end
    if (!wr) begin
      chk_cnt++;
      if (cache2MA_rd_data !== exp_rd) begin
        err_cnt++; $display("FAIL %s rd_data: got %h required %h", nm, cache2MA_rd_data, exp_rd);
      end
    end
    @(posedge clk); #1;
    fin_now = wr ? cache2MA_wr_fin : cache2MA_rd_fin;
    chk_cnt++;
    if (fin_now !== 1'b0) begin err_cnt++; $display("FAIL %s fin_pulse_width: got %0b required 0", nm, fin_now); end
    if (!hit) begin ref_valid[idx] = 1'b1; ref_dirty[idx] = 1'b0; ref_tag[idx] = tag; end
    if (wr) begin ref_mem[addr[26:2]] = wd; ref_dirty[idx] = 1'b1; end
  endtask

  task automatic check_outputs_zero(input string nm);
    logic [383:0] all;
    all = {cache2MA_rd_fin, cache2MA_rd_data, cache2DDR_rd_addr, cache2DDR_rd_en, cache2MA_wr_fin,
           cache2DDR_wr_addr, cache2DDR_wr_data, cache2DDR_wr_en};
    chk_cnt++;
    if (all !== 384'd0) begin err_cnt++; $display("FAIL %s outputs_zero: got %h required 0", nm, all); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    MA2cache_rd_addr = 27'd0; MA2cache_rd_en = 1'b0;
    MA2cache_wr_addr = 27'd0; MA2cache_wr_data = 32'd0; MA2cache_wr_en = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_held");
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("after_reset_idle");
  endtask

  task automatic test_directed();
    do_req("wr_t0i0w0", 1, 0, mk_addr(0, 0, 0), 32'h0000FFFF, 27'd0, 0);
    do_req("wr_i4w1",   1, 0, mk_addr(0, 4, 1), 32'h0000FF00, 27'd0, 0);
    do_req("wr_i4w3",   1, 0, mk_addr(0, 4, 3), 32'h00003333, 27'd0, 0);
    do_req("wr_i8w3",   1, 0, mk_addr(0, 8, 3), 32'h0000F80F, 27'd0, 0);
    do_req("wr_i8w2",   1, 0, mk_addr(0, 8, 2), 32'h00001234, 27'd0, 0);
    do_req("wr_i0w3",   1, 0, mk_addr(0, 0, 3), 32'h0000AAAA, 27'd0, 0);
    do_req("rd_i0w0",   0, 1, mk_addr(0, 0, 0), 32'd0, 27'd0, 0);
    chk_cnt++;
    if (cache2MA_rd_data !== 32'h0000FFFF) begin
      err_cnt++; $display("FAIL rd_i0w0_const: got %h required 0000ffff", cache2MA_rd_data);
    end
    do_req("rd_i4w3",   0, 1, mk_addr(0, 4, 3), 32'd0, 27'd0, 0);
    do_req("wr_t1i4w0", 1, 0, mk_addr(1, 4, 0), 32'h00009999, 27'd0, 0);
    chk_cnt++;
    if (ddr_last_wr_addr !== mk_addr(0, 4, 0) ||
        ddr_last_wr_data !== {32'h00003333, 32'h0, 32'h0000FF00, 32'h0}) begin
      err_cnt++; $display("FAIL victim_i4_const: got %h/%h", ddr_last_wr_addr, ddr_last_wr_data);
    end
    do_req("rd_t0i4w1", 0, 1, mk_addr(0, 4, 1), 32'd0, 27'd0, 0);
    chk_cnt++;
    if (ddr_last_wr_data !== {96'd0, 32'h00009999} || cache2MA_rd_data !== 32'h0000FF00) begin
      err_cnt++; $display("FAIL evict_9999_const: got %h rd %h", ddr_last_wr_data, cache2MA_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    // Busy-time poke: a write raised while the cache is mid-miss must be ignored.
    do_req("b2b_poke_miss", 0, 1, mk_addr(7, 9, 1), 32'd0, 27'd0, 1);
    do_req("b2b_poke_chk",  0, 1, mk_addr(7, 9, 0), 32'd0, 27'd0, 0);
    do_req("b2b_poke_hit",  0, 1, mk_addr(7, 9, 2), 32'd0, 27'd0, 1);
    do_req("b2b_poke_chk2", 0, 1, mk_addr(7, 9, 3), 32'd0, 27'd0, 0);
    // Simultaneous read and write: the write wins, the read is dropped.
    do_req("both_en",       1, 1, mk_addr(7, 9, 1), 32'hC0DE0001, mk_addr(2, 3, 0), 0);
    do_req("both_en_chk",   0, 1, mk_addr(7, 9, 1), 32'd0, 27'd0, 0);
  endtask

  task automatic test_random();
    int idxs [4] = '{0, 1, 4, 255};
    int tag, idx, w, op;
    logic [31:0] d;
    for (int n = 0; n < 80; n++) begin
      tag = $urandom_range(0, 3);
      idx = idxs[$urandom_range(0, 3)];
      w   = $urandom_range(0, 3);
      op  = $urandom_range(0, 9);
      d   = $urandom;
      if (op < 4)      do_req("rand_rd",   0, 1, mk_addr(tag, idx, w), 32'd0, 27'd0, 0);
      else if (op < 9) do_req("rand_wr",   1, 0, mk_addr(tag, idx, w), d, 27'd0, 0);
      else             do_req("rand_both", 1, 1, mk_addr(tag, idx, w), d, mk_addr(tag ^ 1, idx, w), 0);
    end
  endtask

  task automatic test_reset_mid_refill();
    int rc0, cyc;
    // Make idx0 dirty under tag 0, then miss on it with tag 5.
    do_req("pre_rst_wr", 1, 0, mk_addr(0, 0, 2), 32'h5A5A5A5A, 27'd0, 0);
    rc0 = ddr_rd_cnt;
    @(negedge clk);
    MA2cache_rd_addr = mk_addr(5, 0, 0); MA2cache_rd_en = 1'b1;
    @(posedge clk); #1 MA2cache_rd_en = 1'b0;
    cyc = 0;
    while (ddr_rd_cnt == rc0 && cyc < 200) begin @(posedge clk); cyc++; end
    chk_cnt++;
    if (ddr_rd_cnt == rc0) begin err_cnt++; $display("FAIL rst_mid_refill_wait: refill not issued within 200 cycles"); end
    @(negedge clk); rstn = 1'b0;
    #1 check_outputs_zero("rst_mid_refill_async");
    // The write-back of the dirty victim already reached DDR; cached state is lost.
    ref_reset();
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("rst_mid_refill_after");
    do_req("post_rst_rd_i0", 0, 1, mk_addr(0, 0, 0), 32'd0, 27'd0, 0);
    do_req("post_rst_rd_i0w2", 0, 1, mk_addr(0, 0, 2), 32'd0, 27'd0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
